// File: rtl/mem_ctrl_pkg.sv
// Shared widths and response-FSM encoding for the memory request/response path.
// Imported by the arbiter top.
package mem_ctrl_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 31;
  localparam int TID_WIDTH      = 16;

  // Request FIFO word {tid, rw, addr, data} and response FIFO word {tid, data}
  localparam int REQ_WIDTH      = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int DP_DATA_WIDTH  = TID_WIDTH + DATA_WIDTH;
  localparam int VPI_DATA_WIDTH = DATA_WIDTH;

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_HOLD = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after i_ptr,
// searching upward with wrap. NUM_PORTS must be a power of two.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PORT_BITS-1:0] i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [PORT_BITS-1:0] o_gnt_idx,
  output logic                 o_gnt_valid
);

  always_comb begin
    logic [PORT_BITS-1:0] w_cand;
    // NOTE: every output gets a default before the search so no path leaves a
    // value unassigned, which is what keeps this block from inferring latches.
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_cand      = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_cand = i_ptr + PORT_BITS'(off);
      if (!o_gnt_valid && i_req[w_cand]) begin
        o_gnt_valid   = 1'b1;
        o_gnt_idx     = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory request channel among NUM_PORTS requesters (round-robin,
// per-port outstanding limit) and routes responses back by the tid port field.
module mem_req_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_BITS       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 31,
  parameter int TID_WIDTH       = 16,
  parameter int TAG_WIDTH       = TID_WIDTH - PORT_BITS,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_PORTS-1:0]                        req_valid,
  output logic [NUM_PORTS-1:0]                        req_ready,
  input  logic [NUM_PORTS-1:0]                        req_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]             req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]             req_data,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]              req_tag,
  output logic                                        fifo_wr_en,
  output logic [TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                                        fifo_full,
  output logic                                        fifo_rd_en,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0]             fifo_rd_data,
  input  logic                                        fifo_empty,
  output logic [NUM_PORTS-1:0]                        rsp_valid,
  input  logic [NUM_PORTS-1:0]                        rsp_ready,
  output logic [TAG_WIDTH-1:0]                        rsp_tag,
  output logic [DATA_WIDTH-1:0]                       rsp_data,
  output logic                                        err_stray
);

  import mem_ctrl_pkg::*;

  logic [PORT_BITS-1:0]  r_rr_ptr;
  logic [CNT_WIDTH-1:0]  r_cnt [NUM_PORTS];
  rsp_state_t            r_state;
  rsp_state_t            w_state_nxt;
  logic [PORT_BITS-1:0]  r_rsp_port;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_err_stray;

  logic [NUM_PORTS-1:0]  w_eligible;
  logic [NUM_PORTS-1:0]  w_gnt;
  logic [PORT_BITS-1:0]  w_gnt_idx;
  logic                  w_gnt_valid;
  logic                  w_issue_en;
  logic [PORT_BITS-1:0]  w_pop_port;
  logic                  w_pop;
  logic                  w_pop_stray;
  logic                  w_rsp_hs;
  logic [NUM_PORTS-1:0]  w_cnt_inc;
  logic [NUM_PORTS-1:0]  w_cnt_dec;

  // ---------------------------------------------------------------- issue path
  // Nothing is granted while reset is held, so no push happens in a reset cycle.
  assign w_issue_en = reset && !fifo_full;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_eligible[i] = w_issue_en && req_valid[i] &&
                      (r_cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_rr_arbiter (
    .i_req       (w_eligible),
    .i_ptr       (r_rr_ptr),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign req_ready    = w_gnt;
  assign fifo_wr_en   = w_gnt_valid;
  assign fifo_wr_data = {w_gnt_idx,
                         req_tag[w_gnt_idx*TAG_WIDTH +: TAG_WIDTH],
                         req_rw[w_gnt_idx],
                         req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH],
                         req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH]};

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_valid) begin
      r_rr_ptr <= w_gnt_idx + 1'b1;
    end
  end

  // ------------------------------------------------------------- response path
  assign w_pop_port = fifo_rd_data[TID_WIDTH+DATA_WIDTH-1 -: PORT_BITS];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_pop_stray = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      RSP_IDLE: begin
        if (reset && !fifo_empty) begin
          w_pop = 1'b1;
          if (r_cnt[w_pop_port] == '0) begin
            w_pop_stray = 1'b1;
          end else begin
            w_state_nxt = RSP_HOLD;
          end
        end
      end
      RSP_HOLD: begin
        if (rsp_ready[r_rsp_port]) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = RSP_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RSP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_port  <= '0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
      r_err_stray <= 1'b0;
    end else begin
      if (w_pop && !w_pop_stray) begin
        r_rsp_port <= w_pop_port;
        r_rsp_tag  <= fifo_rd_data[DATA_WIDTH +: TAG_WIDTH];
        r_rsp_data <= fifo_rd_data[DATA_WIDTH-1:0];
      end
      if (w_pop_stray) begin
        r_err_stray <= 1'b1;
      end
    end
  end

  assign fifo_rd_en = w_pop;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_data   = r_rsp_data;
  assign err_stray  = r_err_stray;

  always_comb begin
    rsp_valid = '0;
    if (r_state == RSP_HOLD) begin
      rsp_valid[r_rsp_port] = 1'b1;
    end
  end

  // ------------------------------------------------------- outstanding counters
  always_comb begin
    w_cnt_inc = w_gnt;
    w_cnt_dec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cnt_dec[i] = w_rsp_hs && (r_rsp_port == PORT_BITS'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      // NOTE: the counter array is reset element by element; it is control state
      // that gates grants, unlike a data RAM whose contents may power up unknown.
      if (!reset) begin
        r_cnt[i] <= '0;
      end else if (w_cnt_inc[i] && !w_cnt_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (w_cnt_dec[i] && !w_cnt_inc[i]) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the single memory-access request channel among `NUM_PORTS` requesters and routes each returned response to the requester that issued it. Sits in front of the request FIFO that feeds `mem_controller` and behind the response FIFO it fills. It:
- grants requests round-robin;
- stamps the requester index into the top bits of the transaction ID;
- bounds outstanding requests per port;
- buffers one response at a time for delivery.

## Interface
Parameters:
- `NUM_PORTS`, 4: requester count (power of two, ≥2).
- `PORT_BITS`, 2: log2(`NUM_PORTS`).
- `DATA_WIDTH`, 32: data word.
- `ADDR_WIDTH`, 31: address.
- `TID_WIDTH`, 16: transaction ID; top `PORT_BITS` = port, low `TAG_WIDTH` = requester tag.
- `TAG_WIDTH`, `TID_WIDTH-PORT_BITS`: requester tag width.
- `MAX_OUTSTANDING`, 8: per-port in-flight limit.
- `CNT_WIDTH`, 4: counter width, holds 0..`MAX_OUTSTANDING`.

Ports (clock and reset first):
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-low; 0 at a `clk` edge resets all state.
- `req_valid`  in  `NUM_PORTS`: per-port request valid.
- `req_ready`  out  `NUM_PORTS`: per-port grant, one-hot or zero.
- `req_rw`  in  `NUM_PORTS`: 1 = read, 0 = write.
- `req_addr`  in  `NUM_PORTS*ADDR_WIDTH`: packed; port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_data`  in  `NUM_PORTS*DATA_WIDTH`: packed write data.
- `req_tag`  in  `NUM_PORTS*TAG_WIDTH`: packed requester tags.
- `fifo_wr_en`  out  1: push to request FIFO.
- `fifo_wr_data`  out  `TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH`: {tid, rw, addr, data}.
- `fifo_full`  in  1: request FIFO full.
- `fifo_rd_en`  out  1: pop response FIFO (first-word-fall-through).
- `fifo_rd_data`  in  `TID_WIDTH+DATA_WIDTH`: {tid, data}, valid while `!fifo_empty`.
- `fifo_empty`  in  1: response FIFO empty.
- `rsp_valid`  out  `NUM_PORTS`: one-hot response valid.
- `rsp_ready`  in  `NUM_PORTS`: per-port accept.
- `rsp_tag`  out  `TAG_WIDTH`: shared response tag.
- `rsp_data`  out  `DATA_WIDTH`: shared response data.
- `err_stray`  out  1: sticky; a response arrived for a port with zero outstanding.

## Operation
**Issue path** (combinational grant, registered pointer):
- Port i is eligible when `req_valid[i]` is high and `cnt[i] < MAX_OUTSTANDING`.
- When `!fifo_full`, grant the first eligible port at or after `rr_ptr`, searching upward with wrap.
- On a grant to port g:
  - `req_ready[g]=1` and `fifo_wr_en=1`.
  - `fifo_wr_data = {g, req_tag[g], req_rw[g], req_addr[g], req_data[g]}`.
  - `rr_ptr` becomes g+1 mod `NUM_PORTS`.
- With no grant, `rr_ptr` holds.

**Response path** (FSM `RSP_IDLE` / `RSP_HOLD`):
- `RSP_IDLE`, `!fifo_empty`: assert `fifo_rd_en`; capture port p = tid[top], tag and data; go to `RSP_HOLD`.
- If `cnt[p]==0`, the entry is a stray: it is still popped, it is dropped, `err_stray` sets, and the FSM stays in `RSP_IDLE`.
- `RSP_HOLD`: drive `rsp_valid[p]`, `rsp_tag` and `rsp_data`. On `rsp_ready[p]`, return to `RSP_IDLE`; no pop occurs in that cycle.

**Counters:**
- `cnt[i]` +1 on a grant to i; −1 on a response handshake for i; unchanged when both happen in the same cycle.

## Timing
- Reset values: `req_ready=0`, `fifo_wr_en=0`, `fifo_rd_en=0`, `rsp_valid=0`, `rsp_tag=0`, `rsp_data=0`, `err_stray=0`, `rr_ptr=0`, all `cnt=0`, FSM `RSP_IDLE`.
- Issue latency is 0 cycles: request to FIFO push in the same cycle.
- Response latency is 1 cycle from pop to `rsp_valid`.
- Response throughput is at most one per 2 cycles.
- `fifo_full` high: no grant and `fifo_wr_en=0`, regardless of `req_valid`.
- `cnt[i]==MAX_OUTSTANDING`: port i is skipped; other ports are still granted.
- `rsp_valid` is held stable with `rsp_tag`/`rsp_data` until accepted; backpressure stalls only the response path.
- Reset asserted mid-operation: a held response is discarded, and nothing is pushed or popped in the reset cycle.

## Structure
- Shared package `mem_ctrl_pkg`:
  - width constants `DATA_WIDTH`, `ADDR_WIDTH`, `TID_WIDTH`;
  - derived `REQ_WIDTH`, `DP_DATA_WIDTH`, `VPI_DATA_WIDTH`;
  - FSM state encoding `RSP_IDLE=0`, `RSP_HOLD=1`.
- Sub-module `rr_arbiter`: a parameterized round-robin grant (request vector plus pointer in, one-hot grant out). The counters and response FSM stay in the top level.

## Test plan
- All 4 ports request continuously, FIFO never full → grants 0,1,2,3,0 on consecutive cycles; tid[15:14] matches the port.
- Port 2 issues 8 requests with no responses → 9th not granted (`req_ready[2]=0`); port 3 is still granted the same cycle.
- `fifo_full=1` for 3 cycles with all valid → `fifo_wr_en=0` throughout; on release the grant resumes at the held `rr_ptr`.
- Response {tid=16'h4005, data=32'hDEADBEEF} with `cnt[1]=1` → `rsp_valid=4'b0010`, tag `14'h0005`, data `DEADBEEF` one cycle after pop; with `rsp_ready[1]` held 0 for 5 cycles the outputs stay stable; after accept `cnt[1]=0`.
- Response tid=16'hC000 with `cnt[3]=0` → popped, no `rsp_valid`, `err_stray=1` until reset.
- Reset driven low while in `RSP_HOLD` → next cycle `rsp_valid=0`, all counters 0, `rr_ptr=0`.
